// File: rtl/piradip_sysref_gen_if.sv
// Config/strobe and SYSREF output bundle for piradip_sysref_gen; pulse_count exists only
// with PIRADIP_SYSREF_PULSE_CNT_EN defined. Outputs are registered (1 cycle), no backpressure.
interface piradip_sysref_gen_if #(
  parameter int PERIOD_W = 16,
  parameter int BURST_W  = 8
);
  logic                start;
  logic                stop;
  logic                continuous;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] high_cycles;
  logic [BURST_W-1:0]  burst_count;
  logic                sysref_out;
  logic                sysref_edge;
  logic                busy;
  logic                cfg_err;
`ifdef PIRADIP_SYSREF_PULSE_CNT_EN
  logic [31:0]         pulse_count;

  modport master (
    output start, stop, continuous, period, high_cycles, burst_count,
    input  sysref_out, sysref_edge, busy, cfg_err, pulse_count
  );
  modport slave (
    input  start, stop, continuous, period, high_cycles, burst_count,
    output sysref_out, sysref_edge, busy, cfg_err, pulse_count
  );
`else
  modport master (
    output start, stop, continuous, period, high_cycles, burst_count,
    input  sysref_out, sysref_edge, busy, cfg_err
  );
  modport slave (
    input  start, stop, continuous, period, high_cycles, burst_count,
    output sysref_out, sysref_edge, busy, cfg_err
  );
`endif
endinterface

// File: rtl/piradip_sysref_gen.sv
// Periodic / burst SYSREF pulse generator in pl_clk; optional pulse counter via PIRADIP_SYSREF_PULSE_CNT_EN.
// Latency: outputs follow an accepted start by 1 cycle, all registered; no backpressure, stops land on period boundaries.
module piradip_sysref_gen #(
  parameter int PERIOD_W = 16,
  parameter int BURST_W  = 8
) (
  input  logic               pl_clk,
  input  logic               resetn,
  piradip_sysref_gen_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PERIOD_W-1:0] ONE_P  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] TWO_P  = {{(PERIOD_W-2){1'b0}}, 2'b10};
  localparam logic [PERIOD_W-1:0] ZERO_P = '0;
  localparam logic [BURST_W-1:0]  ONE_B  = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] hc_q, hc_d;
  logic [BURST_W-1:0]  rem_q, rem_d;
  logic                cont_q, cont_d;
  logic                stop_pend_q, stop_pend_d;
  logic                cfg_ok;
  logic                wrap;
  logic                busy_d, out_d, edge_d, err_d;
  logic                busy_q, out_q, edge_q, err_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    per_d       = per_q;
    hc_d        = hc_q;
    rem_d       = rem_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    err_d       = 1'b0;

    cfg_ok = (bus.period >= TWO_P) && (bus.high_cycles != ZERO_P) &&
             (bus.high_cycles < bus.period) &&
             (bus.continuous || (bus.burst_count != '0));
    wrap   = (phase_q == (per_q - ONE_P));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            per_d       = bus.period;
            hc_d        = bus.high_cycles;
            rem_d       = bus.burst_count;
            cont_d      = bus.continuous;
            phase_d     = ZERO_P;
            stop_pend_d = 1'b0;
            state_d     = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (wrap) begin
          phase_d = ZERO_P;
          if (!cont_q) rem_d = rem_q - ONE_B;
          // A stop seen on the wrap cycle itself still ends the run here.
          if (stop_pend_q || bus.stop || (!cont_q && (rem_q == ONE_B))) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + ONE_P;
          if (bus.stop) stop_pend_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
    endcase

    // Outputs are computed from next state so they can be registered without extra latency.
    busy_d = (state_d == RUN);
    out_d  = busy_d && (phase_d < hc_d);
    edge_d = busy_d && (phase_d == ZERO_P);
  end

  always_ff @(posedge pl_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      per_q       <= '0;
      hc_q        <= '0;
      rem_q       <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= 1'b0;
      edge_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      per_q       <= per_d;
      hc_q        <= hc_d;
      rem_q       <= rem_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      edge_q      <= edge_d;
      err_q       <= err_d;
    end
  end

  assign bus.sysref_out  = out_q;
  assign bus.sysref_edge = edge_q;
  assign bus.busy        = busy_q;
  assign bus.cfg_err     = err_q;

`ifdef PIRADIP_SYSREF_PULSE_CNT_EN
  logic [31:0] pulse_cnt_q;

  always_ff @(posedge pl_clk or negedge resetn) begin
    if (!resetn) pulse_cnt_q <= '0;
    else if (edge_d) pulse_cnt_q <= pulse_cnt_q + 32'd1;
  end

  assign bus.pulse_count = pulse_cnt_q;
`endif
endmodule

// File: tb/tb_piradip_sysref_gen.sv
// Scoreboarded bench for piradip_sysref_gen: stimulus queues expected per-cycle outputs, monitor checks on negedge.
module tb_piradip_sysref_gen;
  logic pl_clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  string tag = "init";
  logic [3:0] expq[$];

  piradip_sysref_gen_if #(.PERIOD_W(16), .BURST_W(8)) bus ();

  piradip_sysref_gen #(.PERIOD_W(16), .BURST_W(8)) dut (
    .pl_clk (pl_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.sysref_out, bus.sysref_edge, bus.busy, bus.cfg_err};
  endfunction

  // Monitor: {sysref_out, sysref_edge, busy, cfg_err} against the queued expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge pl_clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check(tag, {28'd0, outs()}, {28'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic st, input logic sp, input logic [3:0] e);
    bus.start = st;
    bus.stop  = sp;
    expq.push_back(e);
    @(negedge pl_clk);
    #1;
  endtask

  // Expected waveform of a run: cycle i after the start edge has phase i%p.
  task automatic run_wave(input int p, input int h, input int b, input int c, input int cycles,
                          input int stop_at, input int chg_at, input int chg_p);
    bus.period      = 16'(p);
    bus.high_cycles = 16'(h);
    bus.burst_count = 8'(b);
    bus.continuous  = c[0];
    for (int i = 0; i < cycles; i++) begin
      if (i == chg_at) bus.period = 16'(chg_p);
      step(i == 0, i == stop_at, {((i % p) < h), ((i % p) == 0), 1'b1, 1'b0});
    end
    step(1'b0, stop_at == cycles, 4'b0000);
  endtask

  task automatic bad_start(input int p, input int h, input int b, input int c);
    bus.period      = 16'(p);
    bus.high_cycles = 16'(h);
    bus.burst_count = 8'(b);
    bus.continuous  = c[0];
    step(1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    resetn          = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.continuous  = 1'b0;
    bus.period      = '0;
    bus.high_cycles = '0;
    bus.burst_count = '0;
    #3;
    check("reset_outputs", {28'd0, outs()}, 32'd0);
`ifdef PIRADIP_SYSREF_PULSE_CNT_EN
    check("reset_pulse_count", bus.pulse_count, 32'd0);
`endif
    @(negedge pl_clk);
    #1;
    resetn = 1'b1;
    tag = "idle";
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);

    tag = "burst_8_2_3";        run_wave(8, 2, 3, 0, 24, -1, -1, 0);
    tag = "back_to_back_4_3_2"; run_wave(4, 3, 2, 0, 8, -1, -1, 0);
    tag = "cont_stop_mid";      run_wave(5, 1, 0, 1, 20, 18, -1, 0);
    tag = "cont_stop_last";     run_wave(4, 2, 0, 1, 8, 8, -1, 0);
    tag = "burst_stop";         run_wave(4, 1, 4, 0, 8, 6, -1, 0);
    tag = "start_with_stop";    run_wave(2, 1, 2, 0, 4, 0, -1, 0);

    tag = "stop_in_idle";
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);

    tag = "err_high_eq_period"; bad_start(4, 4, 1, 0);
    tag = "err_period_1";       bad_start(1, 1, 1, 0);
    tag = "err_burst_0";        bad_start(4, 1, 0, 0);
    tag = "err_high_0";         bad_start(4, 0, 1, 1);

    tag = "shadow_period";      run_wave(8, 2, 2, 0, 16, -1, 5, 3);
    tag = "shadow_next";        run_wave(3, 1, 2, 0, 6, -1, -1, 0);
    tag = "burst_max";          run_wave(2, 1, 255, 0, 510, -1, -1, 0);

    tag = "reset_mid_run";
    bus.period      = 16'd8;
    bus.high_cycles = 16'd4;
    bus.continuous  = 1'b1;
    step(1'b1, 1'b0, 4'b1110);
    step(1'b0, 1'b0, 4'b1010);
    resetn = 1'b0;
    #1;
    check("async_reset", {28'd0, outs()}, 32'd0);
    step(1'b0, 1'b0, 4'b0000);
    resetn = 1'b1;
    step(1'b0, 1'b0, 4'b0000);
    tag = "after_reset";        run_wave(4, 1, 1, 0, 4, -1, -1, 0);

`ifdef PIRADIP_SYSREF_PULSE_CNT_EN
    resetn = 1'b0;
    #1;
    check("pulse_count_clear", bus.pulse_count, 32'd0);
    resetn = 1'b1;
    step(1'b0, 1'b0, 4'b0000);
    tag = "count_burst_3";      run_wave(4, 1, 3, 0, 12, -1, -1, 0);
    tag = "count_burst_5";      run_wave(4, 1, 5, 0, 20, -1, -1, 0);
    check("pulse_count_8", bus.pulse_count, 32'd8);
    resetn = 1'b0;
    #1;
    check("pulse_count_reset", bus.pulse_count, 32'd0);
    resetn = 1'b1;
`endif

    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);
    check("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
